// File: rtl/bcd_display_driver.sv
// Binary-to-decimal display driver: converts an unsigned binary value to DIGITS
// BCD digits with an iterative shift-add-3 (double dabble) loop, one input bit per
// clock, then latches active-low seven-segment codes for the board HEX displays.
//
// Ports:
//   clock     - system clock, all state updates on posedge
//   resetn    - asynchronous active-low reset
//   in_value  - unsigned binary value to display (IN_WIDTH bits)
//   in_valid  - in_value valid this cycle, taken when in_ready is high
//   in_ready  - converter idle, can accept a value
//   done      - one-cycle pulse when segments/overflow update
//   overflow  - displayed value exceeds 10^DIGITS-1
//   segments  - active-low gfedcba per digit, digit k in [7k+6:7k], digit 0 = ones
module bcd_display_driver #(
    parameter int unsigned IN_WIDTH = 32,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [IN_WIDTH-1:0]   in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   segments
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SEG_W = 7 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
    // Comparison width wide enough for both the input and 10^DIGITS (<= 10^8).
    localparam int unsigned CMP_W = (IN_WIDTH + 1 > 64) ? IN_WIDTH + 1 : 64;

    localparam logic [63:0] LIMIT = 64'(10) ** DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    // One decimal digit to active-low gfedcba; non-decimal nibbles are blanked.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Display pattern for value 0, shown out of reset.
    function automatic logic [SEG_W-1:0] reset_pattern();
        logic [SEG_W-1:0] p;
        p = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            p[7*k +: 7] = (k == 0 || BLANK_LZ == 0) ? SEG_ZERO : SEG_BLANK;
        end
        return p;
    endfunction

    localparam logic [SEG_W-1:0] SEG_RESET = reset_pattern();

    state_e              state_q,    state_d;
    logic [IN_WIDTH-1:0] shift_q,    shift_d;
    logic [BCD_W-1:0]    bcd_q,      bcd_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic                overflow_q, overflow_d;
    logic [SEG_W-1:0]    segments_q, segments_d;
    logic                done_q,     done_d;
    logic                in_ready_q, in_ready_d;

    logic                in_overflow_c;
    logic [BCD_W-1:0]    bcd_adj_c;
    logic [SEG_W-1:0]    seg_enc_c;

    // Overflow decided once at accept time against the full-precision input.
    assign in_overflow_c = (CMP_W'(in_value) >= CMP_W'(LIMIT));

    // Add-3 correction on every nibble >= 5 before each shift.
    always_comb begin
        bcd_adj_c = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            bcd_adj_c[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                            : bcd_q[4*k +: 4];
        end
    end

    // Segment encoding of the finished BCD value, scanning from the top digit
    // so leading zeros can be blanked.
    always_comb begin
        logic       lead_zero;
        logic [3:0] nib;
        int         k;
        seg_enc_c = '0;
        lead_zero = 1'b1;
        nib       = '0;
        k         = 0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            k   = int'(DIGITS) - 1 - i;
            nib = bcd_q[4*k +: 4];
            if (nib != 4'd0) begin
                lead_zero = 1'b0;
            end
            if (ovf_pend_q) begin
                seg_enc_c[7*k +: 7] = SEG_DASH;
            end else if (BLANK_LZ != 0 && lead_zero && k != 0) begin
                seg_enc_c[7*k +: 7] = SEG_BLANK;
            end else begin
                seg_enc_c[7*k +: 7] = seg7(nib);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        overflow_d = overflow_q;
        segments_d = segments_q;
        done_d     = 1'b0;
        in_ready_d = in_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d    = in_value;
                    bcd_d      = '0;
                    ovf_pend_d = in_overflow_c;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Bits leaving the top of the BCD register are dropped; the
                // overflow flag already covers that case.
                {bcd_d, shift_d} = {bcd_adj_c, shift_q} << 1;
                cnt_d            = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                segments_d = seg_enc_c;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                in_ready_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                in_ready_d = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            overflow_q <= 1'b0;
            segments_q <= SEG_RESET;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            overflow_q <= overflow_d;
            segments_q <= segments_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign segments = segments_q;

endmodule
